// File: rtl/sram_burst_controller.sv
// Async SRAM burst controller: valid/ready request port, registered SRAM strobes,
// per-beat write-data handshake, programmable read/write timing and turnaround gap.
module sram_burst_controller #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 18,
  parameter int LEN_W       = 4,
  parameter int RD_CYCLES   = 2,
  parameter int WR_CYCLES   = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                done,
  output logic                busy,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_dq_o,
  input  logic [DATA_W-1:0]   sram_dq_i,
  output logic                sram_dq_oe,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic [DATA_W/8-1:0] sram_be_n
);
  localparam int BE_W   = DATA_W / 8;
  localparam int MAX_RW = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int MAXC   = (MAX_RW > TURN_CYCLES) ? MAX_RW : TURN_CYCLES;
  localparam int CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_NEXT, WR_FETCH, WR_SETUP, WR_PULSE, WR_HOLD, TURN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   beats_q, beats_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  dq_o_q, dq_o_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [BE_W-1:0]    be_n_q, be_n_d;
  logic               dq_oe_q, dq_oe_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               done_q, done_d;
  logic               wdata_ready_q, wdata_ready_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    beats_d       = beats_q;
    addr_d        = addr_q;
    dq_o_d        = dq_o_q;
    rsp_data_d    = rsp_data_q;
    be_n_d        = be_n_q;
    dq_oe_d       = dq_oe_q;
    ce_n_d        = ce_n_q;
    oe_n_d        = oe_n_q;
    we_n_d        = we_n_q;
    wdata_ready_d = wdata_ready_q;
    rsp_valid_d   = 1'b0;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          beats_d = req_len;
          addr_d  = req_addr;
          ce_n_d  = 1'b0;
          if (req_we) begin
            wdata_ready_d = 1'b1;
            state_d       = WR_FETCH;
          end else begin
            oe_n_d  = 1'b0;
            be_n_d  = '0;
            cnt_d   = CNT_W'(RD_CYCLES - 1);
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = sram_dq_i;
          rsp_valid_d = 1'b1;
          oe_n_d      = 1'b1;
          state_d     = RD_NEXT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_NEXT: begin
        if (beats_q != '0) begin
          beats_d = beats_q - LEN_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          oe_n_d  = 1'b0;
          cnt_d   = CNT_W'(RD_CYCLES - 1);
          state_d = RD_WAIT;
        end else begin
          state_d = TURN;
        end
      end
      WR_FETCH: begin
        if (wdata_valid) begin
          dq_o_d        = wdata;
          be_n_d        = ~wbe;
          dq_oe_d       = 1'b1;
          wdata_ready_d = 1'b0;
          state_d       = WR_SETUP;
        end
      end
      WR_SETUP: begin
        we_n_d  = 1'b0;
        cnt_d   = CNT_W'(WR_CYCLES - 1);
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_q == '0) begin
          we_n_d  = 1'b1;
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_HOLD: begin
        dq_oe_d = 1'b0;
        be_n_d  = '1;
        if (beats_q != '0) begin
          beats_d       = beats_q - LEN_W'(1);
          addr_d        = addr_q + ADDR_W'(1);
          wdata_ready_d = 1'b1;
          state_d       = WR_FETCH;
        end else begin
          state_d = TURN;
        end
      end
      TURN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // Common entry into the turnaround gap from either burst type.
    if (state_d == TURN && state_q != TURN) begin
      done_d  = 1'b1;
      ce_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      we_n_d  = 1'b1;
      be_n_d  = '1;
      dq_oe_d = 1'b0;
      cnt_d   = CNT_W'(TURN_CYCLES - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      beats_q       <= '0;
      addr_q        <= '0;
      dq_o_q        <= '0;
      rsp_data_q    <= '0;
      be_n_q        <= '1;
      dq_oe_q       <= 1'b0;
      ce_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      rsp_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      wdata_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      beats_q       <= beats_d;
      addr_q        <= addr_d;
      dq_o_q        <= dq_o_d;
      rsp_data_q    <= rsp_data_d;
      be_n_q        <= be_n_d;
      dq_oe_q       <= dq_oe_d;
      ce_n_q        <= ce_n_d;
      oe_n_q        <= oe_n_d;
      we_n_q        <= we_n_d;
      rsp_valid_q   <= rsp_valid_d;
      done_q        <= done_d;
      wdata_ready_q <= wdata_ready_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign wdata_ready = wdata_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign done        = done_q;
  assign sram_addr   = addr_q;
  assign sram_dq_o   = dq_o_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_be_n   = be_n_q;
endmodule

// File: tb/tb_sram_burst_controller.sv
// Directed bench for sram_burst_controller with a behavioural async SRAM model.
module tb_sram_burst_controller;
  localparam int DATA_W = 16, ADDR_W = 18, LEN_W = 4;
  localparam int RD_CYCLES = 2, WR_CYCLES = 2, TURN_CYCLES = 1;

  logic clk = 1'b0, rst_n;
  logic req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0] req_len;
  logic wdata_valid, wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic [1:0] wbe;
  logic rsp_valid, done, busy;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_o, sram_dq_i;
  logic sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0] sram_be_n;

  int total = 0, bad = 0, viol = 0;
  logic [15:0] mem [0:262143];

  always #5 clk = ~clk;

  sram_burst_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .RD_CYCLES(RD_CYCLES), .WR_CYCLES(WR_CYCLES), .TURN_CYCLES(TURN_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wbe(wbe),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .busy(busy),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n));

  // SRAM model: combinational read, byte-masked write latched on the rising we_n edge.
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;
  always @(posedge sram_we_n) begin
    if (rst_n === 1'b1 && sram_ce_n === 1'b0 && sram_dq_oe === 1'b1)
      for (int i = 0; i < 2; i++)
        if (!sram_be_n[i]) mem[sram_addr][i*8 +: 8] = sram_dq_o[i*8 +: 8];
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (!sram_we_n && !sram_oe_n) viol++;
      if (sram_dq_oe && (sram_ce_n || !sram_oe_n)) viol++;
    end
  end

  task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL issue_ready: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = a; req_len = l;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({req_ready, wdata_ready} !== 2'b10) begin
      bad++; $display("FAIL rst_handshake: got %b want 10", {req_ready, wdata_ready});
    end
    total++;
    if ({rsp_valid, done, busy} !== 3'b000) begin
      bad++; $display("FAIL rst_status: got %b want 000", {rsp_valid, done, busy});
    end
    total++;
    if (rsp_data !== 16'h0000) begin
      bad++; $display("FAIL rst_rsp_data: got %h want 0000", rsp_data);
    end
    total++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 5'b11111) begin
      bad++; $display("FAIL rst_strobes: got %b want 11111", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n});
    end
    total++;
    if ({sram_addr, sram_dq_o, sram_dq_oe} !== 35'h0) begin
      bad++; $display("FAIL rst_bus: got addr=%h dq=%h oe=%b want 0", sram_addr, sram_dq_o, sram_dq_oe);
    end
  endtask

  task automatic test_single_read();
    int oe_cnt = 0, rsp_k = 0, rsp_cnt = 0, done_k = 0;
    logic [15:0] rd = '0;
    mem[18'h00010] = 16'hBEEF;
    issue(1'b0, 18'h00010, 4'd0);
    for (int k = 1; k <= 10; k++) begin
      if (!sram_oe_n) oe_cnt++;
      if (rsp_valid) begin rsp_k = k; rsp_cnt++; rd = rsp_data; end
      if (done && done_k == 0) done_k = k;
      @(negedge clk);
    end
    total++;
    if (rsp_k != 3 || rsp_cnt != 1) begin
      bad++; $display("FAIL single_rsp_timing: got cycle %0d count %0d want cycle 3 count 1", rsp_k, rsp_cnt);
    end
    total++;
    if (rd !== 16'hBEEF) begin
      bad++; $display("FAIL single_rsp_data: got %h want beef", rd);
    end
    total++;
    if (oe_cnt != 2) begin
      bad++; $display("FAIL single_oe_len: got %0d want 2", oe_cnt);
    end
    total++;
    if (done_k != 4) begin
      bad++; $display("FAIL single_done: got cycle %0d want 4", done_k);
    end
  endtask

  task automatic test_burst_read();
    int n = 0, done_k = 0;
    int rk[4];
    logic [ADDR_W-1:0] ra[4];
    logic [15:0] rd[4];
    logic [ADDR_W-1:0] ea[4] = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
    logic [15:0] ed[4] = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3};
    for (int i = 0; i < 4; i++) begin mem[ea[i]] = ed[i]; rk[i] = 0; ra[i] = '0; rd[i] = '0; end
    issue(1'b0, 18'h3FFFE, 4'd3);
    for (int k = 1; k <= 20; k++) begin
      if (rsp_valid) begin
        if (n < 4) begin rk[n] = k; ra[n] = sram_addr; rd[n] = rsp_data; end
        n++;
      end
      if (done && done_k == 0) done_k = k;
      @(negedge clk);
    end
    total++;
    if (n != 4) begin
      bad++; $display("FAIL burst_beats: got %0d want 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ra[i] !== ea[i] || rd[i] !== ed[i]) begin
        bad++; $display("FAIL burst_beat%0d: got addr=%h data=%h want addr=%h data=%h", i, ra[i], rd[i], ea[i], ed[i]);
      end
      total++;
      if (rk[i] != 3 + 3 * i) begin
        bad++; $display("FAIL burst_spacing%0d: got cycle %0d want %0d", i, rk[i], 3 + 3 * i);
      end
    end
    total++;
    if (done_k != 13) begin
      bad++; $display("FAIL burst_done: got cycle %0d want 13", done_k);
    end
  endtask

  task automatic test_write_gaps();
    logic [15:0] wd[3] = '{16'h1111, 16'h2222, 16'h3333};
    logic [1:0] wb[3] = '{2'b11, 2'b01, 2'b10};
    logic [1:0] ebe[3] = '{2'b00, 2'b10, 2'b01};
    logic [15:0] em[3] = '{16'h1111, 16'hAB22, 16'h33CD};
    int b = 0, wait_c = 0, pulse = 0, np = 0, turn_bad = 0, stuck = 0, k = 0;
    int plen[3];
    logic [1:0] pbe[3];
    logic done_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin mem[18'h100 + i] = 16'hABCD; plen[i] = 0; pbe[i] = 2'b11; end
    issue(1'b1, 18'h00100, 4'd2);
    for (k = 1; k <= 80; k++) begin
      if (done_seen && !busy) break;
      if (!sram_we_n) begin
        pulse++;
        if (pulse == 1 && np < 3) pbe[np] = sram_be_n;
      end else if (pulse > 0) begin
        if (np < 3) plen[np] = pulse;
        np++; pulse = 0;
      end
      if (done) done_seen = 1'b1;
      if (done_seen && sram_dq_oe) turn_bad++;
      if (wdata_valid) begin
        if (wdata_ready !== 1'b0) stuck++;
        wdata_valid = 1'b0; b++; wait_c = 0;
      end else if (wdata_ready && b < 3) begin
        wait_c++;
        if (wait_c > b) begin wdata_valid = 1'b1; wdata = wd[b]; wbe = wb[b]; end
      end
      @(negedge clk);
    end
    total++;
    if (!done_seen || busy) begin
      bad++; $display("FAIL write_timeout: done_seen=%b busy=%b want 1 0", done_seen, busy);
    end
    total++;
    if (b != 3 || np != 3) begin
      bad++; $display("FAIL write_beats: got handshakes=%0d pulses=%0d want 3 3", b, np);
    end
    total++;
    if (stuck != 0) begin
      bad++; $display("FAIL write_ready_drop: got %0d late drops want 0", stuck);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (pbe[i] !== ebe[i] || plen[i] != WR_CYCLES) begin
        bad++; $display("FAIL write_pulse%0d: got be_n=%b len=%0d want be_n=%b len=%0d", i, pbe[i], plen[i], ebe[i], WR_CYCLES);
      end
      total++;
      if (mem[18'h100 + i] !== em[i]) begin
        bad++; $display("FAIL write_mem%0d: got %h want %h", i, mem[18'h100 + i], em[i]);
      end
    end
    total++;
    if (turn_bad != 0) begin
      bad++; $display("FAIL write_turn_dq_oe: got %0d cycles want 0", turn_bad);
    end
  endtask

  task automatic test_read_after_write();
    int last_we_k = 0, first_oe_k = 0, quiet = 0, issue_k = 0, k = 0;
    logic sent = 1'b0, rd_issued = 1'b0, got = 1'b0;
    logic [15:0] rdv = '0;
    mem[18'h200] = 16'h0000;
    issue(1'b1, 18'h00200, 4'd0);
    for (k = 1; k <= 60; k++) begin
      if (rd_issued && k > issue_k + 1 && !busy) break;
      if (!sram_we_n) last_we_k = k;
      if (!sram_oe_n && first_oe_k == 0) first_oe_k = k;
      if (last_we_k > 0 && first_oe_k == 0 && sram_ce_n && sram_oe_n && sram_we_n
          && sram_be_n == 2'b11 && !sram_dq_oe) quiet++;
      if (rsp_valid) begin got = 1'b1; rdv = rsp_data; end
      if (wdata_valid) wdata_valid = 1'b0;
      else if (wdata_ready && !sent) begin
        wdata_valid = 1'b1; wdata = 16'h5A5A; wbe = 2'b11; sent = 1'b1;
      end
      if (req_ready && !rd_issued) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 18'h00200; req_len = 4'd0;
        rd_issued = 1'b1; issue_k = k;
      end else if (rd_issued) req_valid = 1'b0;
      @(negedge clk);
    end
    total++;
    if (!(quiet >= TURN_CYCLES) || first_oe_k <= last_we_k) begin
      bad++; $display("FAIL raw_turnaround: got quiet=%0d we_k=%0d oe_k=%0d want quiet>=%0d", quiet, last_we_k, first_oe_k, TURN_CYCLES);
    end
    total++;
    if (!got || rdv !== 16'h5A5A) begin
      bad++; $display("FAIL raw_data: got valid=%b data=%h want 1 5a5a", got, rdv);
    end
  endtask

  task automatic test_hold_valid();
    int ready_k = 0, done_k = 0, nrsp = 0;
    mem[18'h00010] = 16'hBEEF; mem[18'h00011] = 16'h1234;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL hold_start_ready: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 18'h00010; req_len = 4'd1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done && done_k == 0) done_k = k;
      if (rsp_valid) nrsp++;
      if (req_ready) begin ready_k = k; break; end
    end
    total++;
    if (ready_k != 8 || done_k != 7 || nrsp != 2) begin
      bad++; $display("FAIL hold_single_burst: got ready=%0d done=%0d rsp=%0d want 8 7 2", ready_k, done_k, nrsp);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL hold_second_accept: got busy=%b want 1", busy);
    end
    req_valid = 1'b0;
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL hold_idle_timeout: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_write();
    logic hit = 1'b0, sent = 1'b0;
    issue(1'b1, 18'h00300, 4'd0);
    for (int k = 1; k <= 20; k++) begin
      if (!sram_we_n) begin hit = 1'b1; break; end
      if (wdata_valid) wdata_valid = 1'b0;
      else if (wdata_ready && !sent) begin
        wdata_valid = 1'b1; wdata = 16'hCAFE; wbe = 2'b11; sent = 1'b1;
      end
      @(negedge clk);
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL midrst_reach_pulse: got we_n=%b want 0", sram_we_n);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe, sram_be_n} !== 6'b111011) begin
      bad++; $display("FAIL midrst_strobes: got %b want 111011", {sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe, sram_be_n});
    end
    total++;
    if ({busy, req_ready, wdata_ready, done, rsp_valid} !== 5'b01000) begin
      bad++; $display("FAIL midrst_ctrl: got %b want 01000", {busy, req_ready, wdata_ready, done, rsp_valid});
    end
    wdata_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0; wbe = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single_read();
    test_burst_read();
    test_write_gaps();
    test_read_after_write();
    test_hold_valid();
    test_reset_mid_write();
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL strobe_rules: got %0d violations want 0", viol);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
